// File: rtl/inst_fetch_buffer_pkg.sv
// Shared definitions for the instruction prefetch buffer: bus types, constants
// and FSM state encodings.
package inst_fetch_buffer_pkg;

  typedef logic [31:0] inst_addr_bus_t;
  typedef logic [31:0] inst_bus_t;

  localparam logic      RstEnable   = 1'b0;
  localparam logic      ChipEnable  = 1'b1;
  localparam logic      ChipDisable = 1'b0;
  localparam inst_bus_t ZeroWord    = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    inst_addr_bus_t pc;
    inst_bus_t      inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// Core-side handshake, redirect and ROM signals of the prefetch buffer.
// slave = buffer side, master = core/ROM side.
interface inst_fetch_buffer_if;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;

  modport slave (
    input  flush_i, flush_pc_i, inst_ready_i, rom_data_i,
    output inst_valid_o, inst_o, inst_pc_o, rom_ce_o, rom_addr_o
  );

  modport master (
    output flush_i, flush_pc_i, inst_ready_i, rom_data_i,
    input  inst_valid_o, inst_o, inst_pc_o, rom_ce_o, rom_addr_o
  );
endinterface

// File: rtl/inst_fetch_buffer_fetch_fifo.sv
// Generic DEPTH x 64-bit FIFO: synchronous write, combinational head read,
// synchronous clear. The caller must never pop when empty or push when full.
module fetch_fifo
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  fetch_entry_t i_data,
  output logic [AW:0]  o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction prefetch buffer: fetches ROM words into a FIFO and hands them to the core.
// Optional FETCH_STATS_EN adds fetch/bubble counters as extra output ports.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int             DEPTH    = 4,
  parameter inst_addr_bus_t RESET_PC = 32'h0000_0000,
  localparam int            AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_buffer_if.slave bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        bubble_cnt_o
`endif
);

  fetch_state_e   r_state;
  fetch_state_e   w_state_nxt;
  inst_addr_bus_t r_fetch_pc;
  logic           w_rom_ce;
  logic           w_valid;
  logic           w_pop;
  logic [AW:0]    w_count;
  fetch_entry_t   w_head;
  fetch_entry_t   w_push_data;
  inst_addr_bus_t w_flush_target;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) r_state <= BOOT;
    else                  r_state <= w_state_nxt;
  end

  // DEPTH is a power of two, so the count MSB alone marks a full FIFO.
  always_comb begin
    w_state_nxt = r_state;
    w_rom_ce    = ChipDisable;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     w_rom_ce    = ~w_count[AW] & ~bus.flush_i;
      default: w_state_nxt = BOOT;
    endcase
  end

  assign w_flush_target = bus.flush_pc_i & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable)  r_fetch_pc <= RESET_PC;
    else if (bus.flush_i)  r_fetch_pc <= w_flush_target;
    else if (w_rom_ce)     r_fetch_pc <= r_fetch_pc + 32'd4;
  end

  assign w_valid     = (w_count != '0);
  assign w_pop       = w_valid & bus.inst_ready_i & ~bus.flush_i;
  assign w_push_data = '{pc: r_fetch_pc, inst: bus.rom_data_i};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rom_ce),
    .i_pop   (w_pop),
    .i_clear (bus.flush_i),
    .i_data  (w_push_data),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign bus.rom_ce_o     = w_rom_ce;
  assign bus.rom_addr_o   = r_fetch_pc;
  assign bus.inst_valid_o = w_valid;
  assign bus.inst_o       = w_valid ? w_head.inst : ZeroWord;
  assign bus.inst_pc_o    = w_valid ? w_head.pc   : ZeroWord;

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_rom_ce) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (r_state == RUN && !w_valid && !bus.flush_i) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o  = r_fetch_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule
